// File: rtl/judge_ctrl.sv
// Rhythm-game judgement and game-state controller: debounces the buttons, grades
// track presses against the lcd_ctrl hit flags, and keeps score, combo and lives.
module judge_ctrl #(
  parameter int DEBOUNCE_MS = 10,
  parameter int PERFECT_PTS = 10,
  parameter int NORMAL_PTS  = 5,
  parameter int MAX_LIVES   = 5,
  parameter int SCORE_MAX   = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick,
  input  logic        i_btn_t1,
  input  logic        i_btn_t2,
  input  logic        i_btn_start,
  input  logic        i_hit_t1,
  input  logic        i_pre_hit_t1,
  input  logic        i_hit_t2,
  input  logic        i_pre_hit_t2,
  input  logic        i_miss_t1,
  input  logic        i_miss_t2,
  output logic        o_clear_t1_perf,
  output logic        o_clear_t1_norm,
  output logic        o_clear_t2_perf,
  output logic        o_clear_t2_norm,
  output logic        o_game_start,
  output logic        o_game_over,
  output logic [13:0] o_score,
  output logic [7:0]  o_combo,
  output logic [7:0]  o_max_combo,
  output logic [3:0]  o_lives,
  output logic        o_judge_valid,
  output logic [1:0]  o_judge_result
);

  localparam int CW = (DEBOUNCE_MS < 2) ? 1 : $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW:0]  DB_LIM = (CW+1)'(DEBOUNCE_MS);
  localparam logic [14:0]  PP     = 15'(PERFECT_PTS);
  localparam logic [14:0]  NP     = 15'(NORMAL_PTS);
  localparam logic [14:0]  SMAX   = 15'(SCORE_MAX);
  localparam logic [3:0]   LIVES0 = 4'(MAX_LIVES);

  localparam logic [1:0] RES_PERF = 2'd1;
  localparam logic [1:0] RES_NORM = 2'd2;
  localparam logic [1:0] RES_BAD  = 2'd3;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  // Button index: 0 = track 1, 1 = track 2, 2 = start.
  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {i_btn_start, i_btn_t2, i_btn_t1};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic          s1_reg;
      logic          s2_reg;
      logic          deb_reg;
      logic          press_reg;
      logic [CW-1:0] cnt_reg;
      logic [CW:0]   cnt_inc;

      assign cnt_inc   = {1'b0, cnt_reg} + 1'b1;
      assign press[gi] = press_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg    <= 1'b0;
          s2_reg    <= 1'b0;
          deb_reg   <= 1'b0;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          s1_reg    <= btn_raw[gi];
          s2_reg    <= s1_reg;
          press_reg <= 1'b0;
          if (i_tick) begin
            if (s2_reg == deb_reg) begin
              cnt_reg <= '0;
            end else if (cnt_inc >= DB_LIM) begin
              // Stable long enough: accept the new level; only rising edges are events.
              cnt_reg   <= '0;
              deb_reg   <= s2_reg;
              press_reg <= s2_reg;
            end else begin
              cnt_reg <= cnt_inc[CW-1:0];
            end
          end
        end
      end
    end
  endgenerate

  state_t      state_reg, state_next;
  logic [13:0] score_reg, score_next;
  logic [7:0]  combo_reg, combo_next;
  logic [7:0]  max_reg, max_next;
  logic [3:0]  lives_reg, lives_next;
  logic [1:0]  result_reg, result_next;
  logic        valid_reg, valid_next;
  logic [3:0]  clr_reg, clr_next;   // {t2_norm, t2_perf, t1_norm, t1_perf}

  logic [1:0]  g1, g2;
  logic [14:0] add1, add2, score_sum;
  logic [8:0]  combo_sum;
  logic [3:0]  miss_cnt;
  logic        brk;

  always_comb begin
    state_next  = state_reg;
    score_next  = score_reg;
    combo_next  = combo_reg;
    max_next    = max_reg;
    lives_next  = lives_reg;
    result_next = result_reg;
    valid_next  = 1'b0;
    clr_next    = 4'b0000;

    g1   = i_hit_t1 ? RES_PERF : (i_pre_hit_t1 ? RES_NORM : RES_BAD);
    g2   = i_hit_t2 ? RES_PERF : (i_pre_hit_t2 ? RES_NORM : RES_BAD);
    add1 = !press[0] ? 15'd0 : (g1 == RES_PERF ? PP : (g1 == RES_NORM ? NP : 15'd0));
    add2 = !press[1] ? 15'd0 : (g2 == RES_PERF ? PP : (g2 == RES_NORM ? NP : 15'd0));
    score_sum = {1'b0, score_reg} + add1 + add2;
    combo_sum = {1'b0, combo_reg}
              + {8'd0, press[0] && g1 != RES_BAD}
              + {8'd0, press[1] && g2 != RES_BAD};
    miss_cnt  = {3'd0, i_miss_t1} + {3'd0, i_miss_t2};
    brk = (press[0] && g1 == RES_BAD) || (press[1] && g2 == RES_BAD)
        || i_miss_t1 || i_miss_t2;

    case (state_reg)
      IDLE: begin
        if (press[2]) begin
          state_next = PLAY;
          score_next = '0;
          combo_next = '0;
          max_next   = '0;
          lives_next = LIVES0;
        end
      end
      PLAY: begin
        score_next = (score_sum > SMAX) ? SMAX[13:0] : score_sum[13:0];
        if (brk)
          combo_next = '0;
        else
          combo_next = combo_sum[8] ? 8'd255 : combo_sum[7:0];
        if (combo_next > max_reg)
          max_next = combo_next;
        lives_next = (lives_reg > miss_cnt) ? lives_reg - miss_cnt : 4'd0;
        if (lives_next == 4'd0)
          state_next = OVER;

        valid_next = press[0] || press[1];
        if (press[0])
          result_next = g1;
        else if (press[1])
          result_next = g2;
        clr_next[0] = press[0] && g1 == RES_PERF;
        clr_next[1] = press[0] && g1 == RES_NORM;
        clr_next[2] = press[1] && g2 == RES_PERF;
        clr_next[3] = press[1] && g2 == RES_NORM;
      end
      OVER: begin
        if (press[2])
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      score_reg  <= '0;
      combo_reg  <= '0;
      max_reg    <= '0;
      lives_reg  <= LIVES0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
      clr_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      score_reg  <= score_next;
      combo_reg  <= combo_next;
      max_reg    <= max_next;
      lives_reg  <= lives_next;
      result_reg <= result_next;
      valid_reg  <= valid_next;
      clr_reg    <= clr_next;
    end
  end

  assign o_clear_t1_perf = clr_reg[0];
  assign o_clear_t1_norm = clr_reg[1];
  assign o_clear_t2_perf = clr_reg[2];
  assign o_clear_t2_norm = clr_reg[3];
  assign o_game_start    = (state_reg == PLAY);
  assign o_game_over     = (state_reg == OVER);
  assign o_score         = score_reg;
  assign o_combo         = combo_reg;
  assign o_max_combo     = max_reg;
  assign o_lives         = lives_reg;
  assign o_judge_valid   = valid_reg;
  assign o_judge_result  = result_reg;

endmodule

// File: tb/tb_judge_ctrl.sv
// Directed bench for judge_ctrl with DEBOUNCE_MS=2 and a short 3-clk tick period.
module tb_judge_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_tick = 1'b0;
  logic i_btn_t1 = 1'b0, i_btn_t2 = 1'b0, i_btn_start = 1'b0;
  logic i_hit_t1 = 1'b0, i_pre_hit_t1 = 1'b0, i_hit_t2 = 1'b0, i_pre_hit_t2 = 1'b0;
  logic i_miss_t1 = 1'b0, i_miss_t2 = 1'b0;
  logic o_clear_t1_perf, o_clear_t1_norm, o_clear_t2_perf, o_clear_t2_norm;
  logic o_game_start, o_game_over, o_judge_valid;
  logic [13:0] o_score;
  logic [7:0]  o_combo, o_max_combo;
  logic [3:0]  o_lives;
  logic [1:0]  o_judge_result;

  int n_checks = 0;
  int n_fails  = 0;

  // Pulse counters sampled away from the active edge.
  int c_t1p = 0, c_t1n = 0, c_t2p = 0, c_t2n = 0, c_valid = 0, c_both = 0, c_orphan = 0;
  int s_t1p, s_t1n, s_t2p, s_t2n, s_valid, s_both;

  judge_ctrl #(.DEBOUNCE_MS(2)) dut (
    .clk(clk), .rst(rst), .i_tick(i_tick),
    .i_btn_t1(i_btn_t1), .i_btn_t2(i_btn_t2), .i_btn_start(i_btn_start),
    .i_hit_t1(i_hit_t1), .i_pre_hit_t1(i_pre_hit_t1),
    .i_hit_t2(i_hit_t2), .i_pre_hit_t2(i_pre_hit_t2),
    .i_miss_t1(i_miss_t1), .i_miss_t2(i_miss_t2),
    .o_clear_t1_perf(o_clear_t1_perf), .o_clear_t1_norm(o_clear_t1_norm),
    .o_clear_t2_perf(o_clear_t2_perf), .o_clear_t2_norm(o_clear_t2_norm),
    .o_game_start(o_game_start), .o_game_over(o_game_over),
    .o_score(o_score), .o_combo(o_combo), .o_max_combo(o_max_combo), .o_lives(o_lives),
    .o_judge_valid(o_judge_valid), .o_judge_result(o_judge_result)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    c_t1p  <= c_t1p + int'(o_clear_t1_perf);
    c_t1n  <= c_t1n + int'(o_clear_t1_norm);
    c_t2p  <= c_t2p + int'(o_clear_t2_perf);
    c_t2n  <= c_t2n + int'(o_clear_t2_norm);
    c_valid <= c_valid + int'(o_judge_valid);
    c_both <= c_both + int'(o_clear_t1_perf && o_clear_t2_perf);
    c_orphan <= c_orphan + int'((o_clear_t1_perf || o_clear_t1_norm || o_clear_t2_perf
                                 || o_clear_t2_norm) && !o_judge_valid);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk) i_tick = 1'b1;
    @(negedge clk) i_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic snap();
    @(negedge clk);
    s_t1p = c_t1p; s_t1n = c_t1n; s_t2p = c_t2p; s_t2n = c_t2n;
    s_valid = c_valid; s_both = c_both;
  endtask

  // Hold the selected buttons for 4 ticks, then release for 4 ticks.
  task automatic press(input logic t1, input logic t2, input logic st);
    i_btn_t1 = t1; i_btn_t2 = t2; i_btn_start = st;
    repeat (4) tick();
    i_btn_t1 = 1'b0; i_btn_t2 = 1'b0; i_btn_start = 1'b0;
    repeat (4) tick();
  endtask

  task automatic miss_t1();
    @(negedge clk) i_miss_t1 = 1'b1;
    @(negedge clk) i_miss_t1 = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_start", int'(o_game_start), 0);
    check("rst_over", int'(o_game_over), 0);
    check("rst_score", int'(o_score), 0);
    check("rst_lives", int'(o_lives), 5);
    check("rst_combo", int'(o_combo), 0);
    check("rst_result", int'(o_judge_result), 0);

    // Track presses in IDLE are ignored; start press enters PLAY
    i_hit_t1 = 1'b1;
    snap(); press(1'b1, 1'b0, 1'b0);
    check("idle_t1_ignored", c_valid - s_valid, 0);
    check("idle_stays", int'(o_game_start), 0);
    press(1'b0, 1'b0, 1'b1);
    check("play_start", int'(o_game_start), 1);
    check("play_over", int'(o_game_over), 0);
    check("play_lives", int'(o_lives), 5);
    check("play_score", int'(o_score), 0);

    // Perfect on track 1
    snap(); press(1'b1, 1'b0, 1'b0);
    check("perf_clr_cnt", c_t1p - s_t1p, 1);
    check("perf_valid_cnt", c_valid - s_valid, 1);
    check("perf_score", int'(o_score), 10);
    check("perf_combo", int'(o_combo), 1);
    check("perf_result", int'(o_judge_result), 1);

    // Normal on track 2
    i_hit_t1 = 1'b0; i_hit_t2 = 1'b0; i_pre_hit_t2 = 1'b1;
    snap(); press(1'b0, 1'b1, 1'b0);
    check("norm_clr_cnt", c_t2n - s_t2n, 1);
    check("norm_no_perf", c_t2p - s_t2p, 0);
    check("norm_score", int'(o_score), 15);
    check("norm_combo", int'(o_combo), 2);
    check("norm_result", int'(o_judge_result), 2);

    // Bad on track 1
    i_pre_hit_t2 = 1'b0;
    snap(); press(1'b1, 1'b0, 1'b0);
    check("bad_result", int'(o_judge_result), 3);
    check("bad_combo", int'(o_combo), 0);
    check("bad_max", int'(o_max_combo), 2);
    check("bad_score", int'(o_score), 15);
    check("bad_no_clear", (c_t1p - s_t1p) + (c_t1n - s_t1n), 0);
    check("bad_lives", int'(o_lives), 5);

    // Both tracks Perfect together
    i_hit_t1 = 1'b1; i_hit_t2 = 1'b1;
    snap(); press(1'b1, 1'b1, 1'b0);
    check("dual_score", int'(o_score), 35);
    check("dual_combo", int'(o_combo), 2);
    check("dual_same_edge", c_both - s_both, 1);
    check("dual_valid_once", c_valid - s_valid, 1);
    check("dual_result", int'(o_judge_result), 1);
    i_hit_t2 = 1'b0;

    // Drive score to 9995 (996 Perfects), then one more saturates
    for (int k = 0; k < 996; k++) press(1'b1, 1'b0, 1'b0);
    check("near_score", int'(o_score), 9995);
    check("combo_sat", int'(o_combo), 255);
    check("max_sat", int'(o_max_combo), 255);
    press(1'b1, 1'b0, 1'b0);
    check("score_sat", int'(o_score), 9999);
    check("clear_orphans", c_orphan, 0);

    // Five misses drain lives; OVER on the fifth decrement edge
    for (int k = 0; k < 4; k++) miss_t1();
    check("miss4_lives", int'(o_lives), 1);
    check("miss4_combo", int'(o_combo), 0);
    check("miss4_over", int'(o_game_over), 0);
    miss_t1();
    check("miss5_lives", int'(o_lives), 0);
    check("miss5_over", int'(o_game_over), 1);
    check("miss5_start", int'(o_game_start), 0);
    check("over_max_frozen", int'(o_max_combo), 255);

    // OVER ignores track presses and misses
    snap(); press(1'b1, 1'b0, 1'b0);
    miss_t1();
    check("over_valid", c_valid - s_valid, 0);
    check("over_score", int'(o_score), 9999);
    check("over_lives", int'(o_lives), 0);
    press(1'b0, 1'b0, 1'b1);
    check("idle_start", int'(o_game_start), 0);
    check("idle_over", int'(o_game_over), 0);

    // Bouncing start button: toggles each tick, must not start a game
    for (int k = 0; k < 10; k++) begin
      i_btn_start = ~i_btn_start;
      tick();
    end
    i_btn_start = 1'b0;
    repeat (4) tick();
    check("bounce_no_start", int'(o_game_start), 0);

    // New game clears score/combo/lives, then reset mid-PLAY
    press(1'b0, 1'b0, 1'b1);
    check("new_score", int'(o_score), 0);
    check("new_lives", int'(o_lives), 5);
    check("new_max", int'(o_max_combo), 0);
    press(1'b1, 1'b0, 1'b0);
    check("new_perf_score", int'(o_score), 10);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("mid_rst_start", int'(o_game_start), 0);
    check("mid_rst_score", int'(o_score), 0);
    check("mid_rst_combo", int'(o_combo), 0);
    check("mid_rst_max", int'(o_max_combo), 0);
    check("mid_rst_lives", int'(o_lives), 5);
    check("mid_rst_result", int'(o_judge_result), 0);
    check("mid_rst_valid", int'(o_judge_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
